stg5wb: RTL and testbench
=========================

// Module: stg5wb
// PURPOSE
//   Writeback stage: the consumer end of the stage-4 memory-op latch. Takes the latched pc/opc/
//   tgt_gp/tgt_sr/result bundle, commits result into the GP and SR register files, and serves
//   the decode stage's register reads with same-cycle write-through bypass.
//   Also keeps a retired-instruction counter and a sticky halt flag.
// PARAMETERS
//   DATA_W   24     data/result width (= SIZE_DATA)
//   ADDR_W   24     pc width (= SIZE_ADDR)
//   OPC_W    8      opcode width (= SIZE_OPC)
//   GP_AW    4      GP index bits; GP file has 2**GP_AW entries
//   SR_AW    2      SR index bits; SR file has 2**SR_AW entries
//   CNT_W    32     retired-instruction counter width
//   OPC_NOP  0      bubble opcode; not retired
//   OPC_HLT  8'hFF  halt opcode
// PORTS
//   iw_clk      in   1         clock, rising edge
//   iw_rst      in   1         reset, asynchronous, active-high
//   iw_pc       in   ADDR_W    pc of instruction in writeback
//   iw_opc      in   OPC_W     opcode; OPC_NOP = bubble
//   iw_tgt_gp   in   GP_AW+1   {we, index}; MSB = GP write enable
//   iw_tgt_sr   in   SR_AW+1   {we, index}; MSB = SR write enable
//   iw_result   in   DATA_W    value to commit
//   iw_rd_a     in   GP_AW     GP read port A index
//   ow_rd_a     out  DATA_W    GP read port A data (combinational)
//   iw_rd_b     in   GP_AW     GP read port B index
//   ow_rd_b     out  DATA_W    GP read port B data (combinational)
//   iw_rd_sr    in   SR_AW     SR read index
//   ow_rd_sr    out  DATA_W    SR read data (combinational)
//   ow_ret_pc   out  ADDR_W    pc of last retired instruction (registered)
//   ow_ret_cnt  out  CNT_W     retired-instruction count (registered)
//   ow_halted   out  1         sticky halt flag (registered)
// BEHAVIOUR
//   - Reset (async, any time): all GP/SR entries, ow_ret_pc, ow_ret_cnt = 0; ow_halted = 0.
//     An in-flight write on the reset edge is discarded.
//   - Commit: instr is live when !ow_halted && iw_opc != OPC_NOP. Live && tgt_gp.we && index != 0
//     -> GP[index] <= iw_result on next edge. Live && tgt_sr.we -> SR[index] <= iw_result.
//     GP and SR writes may occur in the same cycle. Latency: 1 edge, visible in array next cycle.
//   - GP[0] reads as 0 always; writes to index 0 are dropped (no bypass either).
//   - Reads: ow_rd_x = (pending GP write this cycle && iw_rd_x == write index) ? iw_result
//     : GP[iw_rd_x]. Same write-through rule for ow_rd_sr. Ports A/B independent; A==B allowed.
//   - Retire: each live instr -> ow_ret_cnt += 1 (wraps modulo 2**CNT_W), ow_ret_pc <= iw_pc.
//   - Halt: live instr with iw_opc == OPC_HLT retires (cnt+1, pc captured), performs its own
//     tgt writes if flagged, and sets ow_halted on the same edge. While ow_halted: no writes,
//     no counting, ow_ret_pc frozen; reads still served (no bypass since nothing pending).
//     Only iw_rst clears ow_halted.
//   - we=0 with nonzero index: no write, no bypass. Non-NOP with both we=0 still retires.
// TESTING
//   1. Reset mid-run: write GP3=0x123456, assert iw_rst -> ow_rd_a(3)=0, ow_ret_cnt=0, halted=0.
//   2. opc=0x10, tgt_gp={1,5}, result=0xABCDEF; iw_rd_a=5 same cycle -> ow_rd_a=0xABCDEF
//      (bypass); next cycle GP5=0xABCDEF from array, ow_ret_cnt=1, ow_ret_pc=iw_pc.
//   3. tgt_gp={1,0}, result=0xFFFFFF -> ow_rd_a(0)=0 that cycle and after; cnt still +1.
//   4. opc=OPC_NOP, tgt_gp={1,2}, result=0x55 -> GP2 unchanged, ow_ret_cnt unchanged.
//   5. opc=OPC_HLT, tgt_sr={1,1}, result=0x7 -> SR1=7, halted=1, cnt+1; then opc=0x10,
//      tgt_gp={1,4} -> GP4 unchanged, cnt frozen until reset.
//   6. Preload ow_ret_cnt to 2**CNT_W-1 via counted retires (CNT_W=4 build), one more -> 0.

Source files
------------

// File: rtl/stg5wb.sv
// Writeback stage: commits the stage-4 result into the GP and SR register
// files, serves decode-stage register reads with same-cycle write-through,
// and tracks the last retired pc, a retired-instruction count and a sticky
// halt flag.
module stg5wb #(
   parameter int               DATA_W  = 24,
   parameter int               ADDR_W  = 24,
   parameter int               OPC_W   = 8,
   parameter int               GP_AW   = 4,
   parameter int               SR_AW   = 2,
   parameter int               CNT_W   = 32,
   parameter logic [OPC_W-1:0] OPC_NOP = 8'h00,
   parameter logic [OPC_W-1:0] OPC_HLT = 8'hFF
) (
   input  logic              iw_clk,
   input  logic              iw_rst,
   input  logic [ADDR_W-1:0] iw_pc,
   input  logic [OPC_W-1:0]  iw_opc,
   input  logic [GP_AW:0]    iw_tgt_gp,
   input  logic [SR_AW:0]    iw_tgt_sr,
   input  logic [DATA_W-1:0] iw_result,
   input  logic [GP_AW-1:0]  iw_rd_a,
   output logic [DATA_W-1:0] ow_rd_a,
   input  logic [GP_AW-1:0]  iw_rd_b,
   output logic [DATA_W-1:0] ow_rd_b,
   input  logic [SR_AW-1:0]  iw_rd_sr,
   output logic [DATA_W-1:0] ow_rd_sr,
   output logic [ADDR_W-1:0] ow_ret_pc,
   output logic [CNT_W-1:0]  ow_ret_cnt,
   output logic              ow_halted
);

   localparam int GP_N = 2**GP_AW;
   localparam int SR_N = 2**SR_AW;

   logic [DATA_W-1:0] r_gp [GP_N];
   logic [DATA_W-1:0] r_sr [SR_N];
   logic [ADDR_W-1:0] r_ret_pc;
   logic [CNT_W-1:0]  r_ret_cnt;
   logic              r_halted;

   logic              w_live;
   logic [GP_AW-1:0]  w_gp_idx;
   logic [SR_AW-1:0]  w_sr_idx;
   logic              w_gp_we;
   logic              w_sr_we;

   // Decode whether the instruction in writeback commits anything this cycle.
   // GP index 0 is hard-wired to zero, so a write aimed there is simply dropped.
   always_comb begin
      w_live   = !r_halted && (iw_opc != OPC_NOP);
      w_gp_idx = iw_tgt_gp[GP_AW-1:0];
      w_sr_idx = iw_tgt_sr[SR_AW-1:0];
      w_gp_we  = w_live && iw_tgt_gp[GP_AW] && (w_gp_idx != {GP_AW{1'b0}});
      w_sr_we  = w_live && iw_tgt_sr[SR_AW];
   end

   // Read ports: a write pending this cycle to the same index is forwarded
   // so decode sees the value before it lands in the array.
   always_comb begin
      ow_rd_a  = (w_gp_we && (iw_rd_a == w_gp_idx)) ? iw_result : r_gp[iw_rd_a];
      ow_rd_b  = (w_gp_we && (iw_rd_b == w_gp_idx)) ? iw_result : r_gp[iw_rd_b];
      ow_rd_sr = (w_sr_we && (iw_rd_sr == w_sr_idx)) ? iw_result : r_sr[iw_rd_sr];
   end

   // Register-file commit, retire bookkeeping and sticky halt.
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         for (int i = 0; i < GP_N; i++) begin
            r_gp[i] <= {DATA_W{1'b0}};
         end
         for (int j = 0; j < SR_N; j++) begin
            r_sr[j] <= {DATA_W{1'b0}};
         end
         r_ret_pc  <= {ADDR_W{1'b0}};
         r_ret_cnt <= {CNT_W{1'b0}};
         r_halted  <= 1'b0;
      end else begin
         if (w_gp_we) begin
            r_gp[w_gp_idx] <= iw_result;
         end
         if (w_sr_we) begin
            r_sr[w_sr_idx] <= iw_result;
         end
         if (w_live) begin
            r_ret_pc  <= iw_pc;
            r_ret_cnt <= r_ret_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (iw_opc == OPC_HLT) begin
               r_halted <= 1'b1;
            end
         end
      end
   end

   assign ow_ret_pc  = r_ret_pc;
   assign ow_ret_cnt = r_ret_cnt;
   assign ow_halted  = r_halted;

endmodule

// File: tb/tb_stg5wb.sv
// Directed-vector bench for stg5wb. A second instance built with a 4-bit
// retire counter shares all inputs so counter wrap can be exercised.
module tb_stg5wb;

   logic        iw_clk;
   logic        iw_rst;
   logic [23:0] iw_pc;
   logic [7:0]  iw_opc;
   logic [4:0]  iw_tgt_gp;
   logic [2:0]  iw_tgt_sr;
   logic [23:0] iw_result;
   logic [3:0]  iw_rd_a;
   logic [3:0]  iw_rd_b;
   logic [1:0]  iw_rd_sr;
   logic [23:0] ow_rd_a, ow_rd_b, ow_rd_sr, ow_ret_pc;
   logic [31:0] ow_ret_cnt;
   logic        ow_halted;
   logic [23:0] w4_rd_a, w4_rd_b, w4_rd_sr, w4_ret_pc;
   logic [3:0]  w4_ret_cnt;
   logic        w4_halted;

   int n_cmp;
   int n_err;

   stg5wb u_dut (
      .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_pc(iw_pc), .iw_opc(iw_opc),
      .iw_tgt_gp(iw_tgt_gp), .iw_tgt_sr(iw_tgt_sr), .iw_result(iw_result),
      .iw_rd_a(iw_rd_a), .ow_rd_a(ow_rd_a), .iw_rd_b(iw_rd_b), .ow_rd_b(ow_rd_b),
      .iw_rd_sr(iw_rd_sr), .ow_rd_sr(ow_rd_sr), .ow_ret_pc(ow_ret_pc),
      .ow_ret_cnt(ow_ret_cnt), .ow_halted(ow_halted)
   );

   stg5wb #(.CNT_W(4)) u_dut4 (
      .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_pc(iw_pc), .iw_opc(iw_opc),
      .iw_tgt_gp(iw_tgt_gp), .iw_tgt_sr(iw_tgt_sr), .iw_result(iw_result),
      .iw_rd_a(iw_rd_a), .ow_rd_a(w4_rd_a), .iw_rd_b(iw_rd_b), .ow_rd_b(w4_rd_b),
      .iw_rd_sr(iw_rd_sr), .ow_rd_sr(w4_rd_sr), .ow_ret_pc(w4_ret_pc),
      .ow_ret_cnt(w4_ret_cnt), .ow_halted(w4_halted)
   );

   // 10-time-unit clock.
   initial begin
      iw_clk = 1'b0;
      forever #5 iw_clk = ~iw_clk;
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [7:0] opc, input logic [23:0] pc,
                        input logic [4:0] tgp, input logic [2:0] tsr,
                        input logic [23:0] res);
      iw_opc    = opc;
      iw_pc     = pc;
      iw_tgt_gp = tgp;
      iw_tgt_sr = tsr;
      iw_result = res;
   endtask

   // Advance one clock edge and settle 1 unit past it.
   task automatic step();
      @(posedge iw_clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      iw_rst = 1'b1;
      drive(8'h00, 24'h0, 5'h00, 3'h0, 24'h0);
      iw_rd_a = 4'd3; iw_rd_b = 4'd0; iw_rd_sr = 2'd0;
      step(); step();
      iw_rst = 1'b0;
      #1;
      check_val("rst_cnt", ow_ret_cnt, 64'd0);
      check_val("rst_pc", ow_ret_pc, 64'd0);
      check_val("rst_halt", ow_halted, 64'd0);
      check_val("rst_rd_a3", ow_rd_a, 64'd0);

      // Write GP5 with same-cycle bypass on both ports.
      drive(8'h10, 24'h000100, 5'h15, 3'h0, 24'hABCDEF);
      iw_rd_a = 4'd5; iw_rd_b = 4'd6;
      #1;
      check_val("byp_a5", ow_rd_a, 64'hABCDEF);
      check_val("nobyp_b6", ow_rd_b, 64'd0);
      step();
      drive(8'h00, 24'h0, 5'h00, 3'h0, 24'h0);
      iw_rd_b = 4'd5;
      #1;
      check_val("arr_a5", ow_rd_a, 64'hABCDEF);
      check_val("arr_b5", ow_rd_b, 64'hABCDEF);
      check_val("cnt_1", ow_ret_cnt, 64'd1);
      check_val("pc_1", ow_ret_pc, 64'h000100);

      // Write to GP0 is dropped, but the instruction still retires.
      drive(8'h10, 24'h000104, 5'h10, 3'h0, 24'hFFFFFF);
      iw_rd_a = 4'd0;
      #1;
      check_val("gp0_byp", ow_rd_a, 64'd0);
      step();
      drive(8'h00, 24'h0, 5'h00, 3'h0, 24'h0);
      #1;
      check_val("gp0_arr", ow_rd_a, 64'd0);
      check_val("cnt_2", ow_ret_cnt, 64'd2);
      check_val("pc_2", ow_ret_pc, 64'h000104);

      // NOP bubble: no write, no bypass, no retire.
      drive(8'h00, 24'h000108, 5'h12, 3'h0, 24'h000055);
      iw_rd_a = 4'd2;
      #1;
      check_val("nop_byp", ow_rd_a, 64'd0);
      step();
      check_val("nop_arr", ow_rd_a, 64'd0);
      check_val("nop_cnt", ow_ret_cnt, 64'd2);
      check_val("nop_pc", ow_ret_pc, 64'h000104);

      // we=0 with nonzero index: no write, no bypass, still retires.
      drive(8'h20, 24'h00010C, 5'h07, 3'h3, 24'h000111);
      iw_rd_a = 4'd7; iw_rd_sr = 2'd3;
      #1;
      check_val("we0_byp", ow_rd_a, 64'd0);
      check_val("we0_srbyp", ow_rd_sr, 64'd0);
      step();
      drive(8'h00, 24'h0, 5'h00, 3'h0, 24'h0);
      #1;
      check_val("we0_arr", ow_rd_a, 64'd0);
      check_val("we0_cnt", ow_ret_cnt, 64'd3);
      check_val("we0_pc", ow_ret_pc, 64'h00010C);

      // Simultaneous GP6 and SR2 write.
      drive(8'h30, 24'h000110, 5'h16, 3'h6, 24'h00BEEF);
      iw_rd_a = 4'd6; iw_rd_sr = 2'd2;
      #1;
      check_val("dual_byp_gp", ow_rd_a, 64'h00BEEF);
      check_val("dual_byp_sr", ow_rd_sr, 64'h00BEEF);
      step();
      drive(8'h00, 24'h0, 5'h00, 3'h0, 24'h0);
      #1;
      check_val("dual_arr_gp", ow_rd_a, 64'h00BEEF);
      check_val("dual_arr_sr", ow_rd_sr, 64'h00BEEF);
      check_val("dual_cnt", ow_ret_cnt, 64'd4);

      // Reset mid-run after writing GP3; in-flight write during reset discarded.
      drive(8'h10, 24'h000114, 5'h13, 3'h0, 24'h123456);
      iw_rd_a = 4'd3;
      step();
      drive(8'h00, 24'h0, 5'h00, 3'h0, 24'h0);
      #1;
      check_val("gp3_pre_rst", ow_rd_a, 64'h123456);
      #2;
      iw_rst = 1'b1;
      #1;
      check_val("rst_gp3", ow_rd_a, 64'd0);
      check_val("rst_cnt_mid", ow_ret_cnt, 64'd0);
      check_val("rst_halt_mid", ow_halted, 64'd0);
      drive(8'h10, 24'h000118, 5'h13, 3'h0, 24'h654321);
      step();
      drive(8'h00, 24'h0, 5'h00, 3'h0, 24'h0);
      iw_rst = 1'b0;
      iw_rd_b = 4'd6; iw_rd_sr = 2'd2;
      #1;
      check_val("rst_drop_gp3", ow_rd_a, 64'd0);
      check_val("rst_gp6", ow_rd_b, 64'd0);
      check_val("rst_sr2", ow_rd_sr, 64'd0);
      check_val("rst_cnt_hold", ow_ret_cnt, 64'd0);

      // Counter wrap on the 4-bit build: 15 retires, then one more.
      for (int i = 0; i < 15; i++) begin
         drive(8'h01, 24'h000400 + 24'(i), 5'h00, 3'h0, 24'h0);
         step();
      end
      drive(8'h00, 24'h0, 5'h00, 3'h0, 24'h0);
      #1;
      check_val("cnt4_max", w4_ret_cnt, 64'd15);
      check_val("cnt32_15", ow_ret_cnt, 64'd15);
      check_val("pc_15", ow_ret_pc, 64'h00040E);
      drive(8'h01, 24'h000500, 5'h00, 3'h0, 24'h0);
      step();
      drive(8'h00, 24'h0, 5'h00, 3'h0, 24'h0);
      #1;
      check_val("cnt4_wrap", w4_ret_cnt, 64'd0);
      check_val("cnt32_16", ow_ret_cnt, 64'd16);

      // Halt writes SR1, retires, and sets halted on the same edge.
      drive(8'hFF, 24'h000200, 5'h00, 3'h5, 24'h000007);
      iw_rd_sr = 2'd1;
      #1;
      check_val("hlt_byp_sr", ow_rd_sr, 64'd7);
      step();
      drive(8'h10, 24'h000300, 5'h14, 3'h6, 24'h000999);
      iw_rd_a = 4'd4; iw_rd_sr = 2'd2;
      #1;
      check_val("hlt_flag", ow_halted, 64'd1);
      check_val("hlt_cnt", ow_ret_cnt, 64'd17);
      check_val("hlt_pc", ow_ret_pc, 64'h000200);
      check_val("halted_nobyp_gp", ow_rd_a, 64'd0);
      check_val("halted_nobyp_sr", ow_rd_sr, 64'd0);
      step();
      step();
      iw_rd_sr = 2'd1;
      #1;
      check_val("halted_sr1", ow_rd_sr, 64'd7);
      check_val("halted_gp4", ow_rd_a, 64'd0);
      check_val("halted_cnt", ow_ret_cnt, 64'd17);
      check_val("halted_pc", ow_ret_pc, 64'h000200);
      check_val("halted_sticky", ow_halted, 64'd1);

      // Only reset clears halt.
      drive(8'h00, 24'h0, 5'h00, 3'h0, 24'h0);
      iw_rst = 1'b1;
      #1;
      check_val("unhalt", ow_halted, 64'd0);
      check_val("unhalt_sr1", ow_rd_sr, 64'd0);
      iw_rst = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
